// File: rtl/coproc_sequencer.sv
// Coprocessor instruction sequencer: fetches 22-bit program words, issues them one
// at a time and waits for completion, with run/step control and halt/error trapping.
module coproc_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        step,
  input  logic        clear,
  output logic [4:0]  prog_addr,
  input  logic [21:0] prog_data,
  output logic [21:0] instr,
  output logic        instr_valid,
  input  logic        instr_done,
  output logic        busy,
  output logic        halted,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [4:0]  pc,
  output logic [7:0]  exec_count
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT, HALT, ERR} state_t;

  localparam logic [4:0] LAST_PC     = 5'(PROG_DEPTH - 1);
  localparam logic [7:0] LAST_WAIT   = 8'(TIMEOUT - 1);
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_OPCODE  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  state_t      state_q, state_d;
  logic [4:0]  pc_q, pc_d;
  logic [21:0] instr_q, instr_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  exec_cnt_q, exec_cnt_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        continuous_q, continuous_d;
  logic [3:0]  opcode;

  assign opcode = prog_data[3:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      instr_q      <= '0;
      wait_cnt_q   <= '0;
      exec_cnt_q   <= '0;
      err_code_q   <= ERR_NONE;
      continuous_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      wait_cnt_q   <= wait_cnt_d;
      exec_cnt_q   <= exec_cnt_d;
      err_code_q   <= err_code_d;
      continuous_q <= continuous_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    wait_cnt_d   = wait_cnt_q;
    exec_cnt_d   = exec_cnt_q;
    err_code_d   = err_code_q;
    continuous_d = continuous_q;
    case (state_q)
      IDLE: begin
        if (run) begin
          continuous_d = 1'b1;
          state_d      = FETCH;
        end else if (step) begin
          continuous_d = 1'b0;
          state_d      = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        // The word is captured even when it halts or traps, so it stays visible.
        instr_d = prog_data;
        if (opcode == 4'd0) begin
          state_d = HALT;
        end else if (opcode >= 4'd12) begin
          state_d    = ERR;
          err_code_d = ERR_OPCODE;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_cnt_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // Completion is checked before the timeout so a done on the last cycle wins.
        if (instr_done) begin
          if (exec_cnt_q != 8'hFF) exec_cnt_d = exec_cnt_q + 8'd1;
          if (pc_q == LAST_PC) begin
            pc_d    = '0;
            state_d = HALT;
          end else begin
            pc_d    = pc_q + 5'd1;
            state_d = continuous_q ? FETCH : IDLE;
          end
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d    = ERR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      HALT, ERR: begin
        if (clear) begin
          state_d    = IDLE;
          pc_d       = '0;
          err_code_d = ERR_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign prog_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign busy        = (state_q != IDLE) && (state_q != HALT) && (state_q != ERR);
  assign halted      = (state_q == HALT);
  assign error       = (state_q == ERR);
  assign err_code    = err_code_q;
  assign exec_count  = exec_cnt_q;

endmodule
